icache_refill_responder: RTL

- Memory-side responder for the instruction-cache refill port.
- Accepts one line-refill request (stb plus line address).
- Fetches the line's words, one at a time, from a single-word backing memory port into an internal line buffer.
- Returns the line to the cache as one gap-free burst: ack held high for LINE_WORDS consecutive cycles, words in ascending order. The cache counts words by consecutive ack cycles, so a gap is illegal.
- Sits between the icache and the memory controller / BRAM arbiter.

---
 rtl/icache_refill_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/icache_refill_responder.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_responder
// Purpose  : fetches one icache line word-by-word from backing memory, then
//            returns it to the cache as a single gap-free ack burst.
// Revision : 1.0
// ============================================================================
module icache_refill_responder #(
  parameter int LINE_LOG2 = 3,
  parameter int ADDR_HI   = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memory_stb,
  input  logic [ADDR_HI:2] memory_addr,
  output logic [31:0]      memory_dout,
  output logic             memory_ack,
  output logic             ram_stb,
  output logic [ADDR_HI:2] ram_addr,
  input  logic [31:0]      ram_dout,
  input  logic             ram_ack
);

  localparam int                   LINE_WORDS = 2 ** LINE_LOG2;
  localparam logic [LINE_LOG2-1:0] CNT_ONE    = LINE_LOG2'(1);
  localparam logic [LINE_LOG2-1:0] CNT_LAST   = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2,
    ST_GUARD  = 2'd3
  } state_t;

  state_t                      state_q;
  logic [ADDR_HI:2+LINE_LOG2]  line_q;
  logic [LINE_LOG2-1:0]        fetch_cnt_q;
  logic [LINE_LOG2-1:0]        fetch_cnt_d;
  logic [LINE_LOG2-1:0]        stream_cnt_q;
  logic [LINE_LOG2-1:0]        stream_cnt_d;
  logic [31:0]                 line_buf_q [LINE_WORDS];
  logic [31:0]                 memory_dout_q;
  logic                        memory_ack_q;
  logic                        ram_stb_q;
  logic [ADDR_HI:2]            ram_addr_q;
  logic                        fetch_hs;

  // Requests are line-granular; the word offset inside the line is dropped.
  logic unused_addr_lo;
  assign unused_addr_lo = ^memory_addr[LINE_LOG2+1:2];

  assign fetch_cnt_d  = fetch_cnt_q + CNT_ONE;
  assign stream_cnt_d = stream_cnt_q + CNT_ONE;
  assign fetch_hs     = (state_q == ST_FETCH) && ram_ack;

  always_ff @(posedge clk) begin
    if (fetch_hs) begin
      line_buf_q[fetch_cnt_q] <= ram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      line_q        <= '0;
      fetch_cnt_q   <= '0;
      stream_cnt_q  <= '0;
      ram_stb_q     <= 1'b0;
      ram_addr_q    <= '0;
      memory_ack_q  <= 1'b0;
      memory_dout_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (memory_stb) begin
            line_q      <= memory_addr[ADDR_HI:2+LINE_LOG2];
            ram_addr_q  <= {memory_addr[ADDR_HI:2+LINE_LOG2], {LINE_LOG2{1'b0}}};
            fetch_cnt_q <= '0;
            ram_stb_q   <= 1'b1;
            state_q     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (ram_ack) begin
            fetch_cnt_q <= fetch_cnt_d;
            ram_addr_q  <= {line_q, fetch_cnt_d};
            // Word 0 was buffered long ago, so the burst can start on the
            // very edge that captures the last word.
            if (fetch_cnt_q == CNT_LAST) begin
              ram_stb_q     <= 1'b0;
              memory_ack_q  <= 1'b1;
              memory_dout_q <= line_buf_q[0];
              stream_cnt_q  <= '0;
              state_q       <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (stream_cnt_q == CNT_LAST) begin
            memory_ack_q  <= 1'b0;
            memory_dout_q <= '0;
            state_q       <= ST_GUARD;
          end else begin
            stream_cnt_q  <= stream_cnt_d;
            memory_dout_q <= line_buf_q[stream_cnt_d];
          end
        end
        ST_GUARD: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign memory_dout = memory_dout_q;
  assign memory_ack  = memory_ack_q;
  assign ram_stb     = ram_stb_q;
  assign ram_addr    = ram_addr_q;

endmodule
`default_nettype wire
